bcd_to_bin_seq: RTL and testbench
=================================

BCD_TO_BIN_SEQ -- requirements
Module: bcd_to_bin_seq

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of packed BCD input digits.
REQ-002 SHALL have parameter BIN_W, default 14, binary result width and iteration count; must be at least ceil(log2(10^DIGITS)).
REQ-003 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, request to convert bcd_in.
REQ-006 SHALL have port bcd_in, input, 4*DIGITS, packed BCD with digit 0 in bits [3:0].
REQ-007 SHALL have port busy, output, 1, conversion in progress.
REQ-008 SHALL have port done, output, 1, one-cycle pulse marking a valid result.
REQ-009 SHALL have port bin_out, output, BIN_W, registered binary result.
REQ-010 SHALL have port err, output, 1, invalid-digit flag, qualified by done.

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, DONE with registered outputs.
REQ-012 IDLE: start=1 at an edge SHALL capture bcd_in into shift register, clear working binary register and iteration counter, and enter SHIFT.
REQ-013 IDLE with start=0 SHALL hold all state; bin_out keeps the last result.
REQ-014 SHIFT, each cycle: right-shift {bcd_reg, bin_reg} by 1 with 0 into BCD MSB; then subtract 3 from every BCD digit whose shifted value is >= 8.
REQ-015 SHIFT SHALL last exactly BIN_W cycles, then load bin_out from bin_reg and enter DONE.
REQ-016 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-017 Latency: start sampled at edge 0 SHALL make done high between edges BIN_W and BIN_W+1 (14/15 at defaults).
REQ-018 busy SHALL be 1 exactly while in SHIFT.
REQ-019 start SHALL be ignored in SHIFT and DONE; no queuing.
REQ-020 start held high SHALL launch a new conversion on the first IDLE edge after DONE, giving back-to-back spacing of BIN_W+2 cycles.
REQ-021 bcd_in SHALL be sampled only at the accepting edge; later changes have no effect.
REQ-022 Arithmetic SHALL be unsigned; max input 10^DIGITS-1 converts without overflow.

Reset
REQ-023 reset=1 SHALL force state IDLE, busy=0, done=0, err=0, bin_out=0, and clear the counter and working registers.
REQ-024 reset SHALL take priority over start and SHALL abort a conversion mid-operation with no done pulse.
REQ-025 The first edge after reset deasserts SHALL be able to accept start.

Configuration
REQ-026 Macro BCD_ERR_CHECK_EN defined: any captured digit > 9 SHALL set err=1 with done, and bin_out SHALL be loaded with 0.
REQ-027 Macro BCD_ERR_CHECK_EN undefined: err SHALL be tied 0; invalid digits convert by the REQ-014 algorithm with a deterministic, unspecified result.

Structure
REQ-028 Shared package bcd_pkg SHALL hold the FSM state type and default DIGITS/BIN_W constants.
REQ-029 Per-digit correction (>=8 then subtract 3) SHALL be a combinational sub-module bcd_digit_sub3, instantiated DIGITS times.
REQ-030 Iteration counter width SHALL be $clog2(BIN_W+1).

Verification
REQ-031 start, bcd_in=16'h9999 -> done at edge 14, bin_out=9999 (14'h270F), err=0.
REQ-032 start, bcd_in=16'h0000 -> done at edge 14, bin_out=0; then 16'h0255 -> bin_out=255.
REQ-033 start pulsed again at edges 3 and 14 during a conversion -> one done only, result from the first capture.
REQ-034 reset=1 at edge 7 of a conversion -> busy=0, no done pulse, bin_out=0; a following start converts normally.
REQ-035 With BCD_ERR_CHECK_EN, bcd_in=16'h00A0 -> done with err=1, bin_out=0; without the macro, err stays 0.
REQ-036 start held high for 40 cycles with bcd_in=16'h1234 -> done pulses at edges 14 and 30, bin_out=1234 each time.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter.
// Contents: FSM state type and default DIGITS / BIN_W constants.
// No logic; imported by bcd_to_bin_seq.
package bcd_pkg;

   // Four packed BCD digits (0..9999) need 14 result bits / 14 iterations.
   localparam int BCD_DIGITS_DEF = 4;
   localparam int BCD_BIN_W_DEF  = 14;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage : bcd_pkg

// File: rtl/bcd_digit_sub3.sv
// Reverse double-dabble correction for one BCD digit: subtract 3 when >= 8.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input.
// Ports: d - shifted digit value, q - corrected digit.
module bcd_digit_sub3 (
   input  logic [3:0] d,
   output logic [3:0] q
);

   // After a right shift a digit that held 10..19 shows up as 8..9+5; taking
   // 3 off restores a proper halving in decimal (the shifted-in 8 is worth 5).
   always_comb begin
      q = d;
      if (d >= 4'd8) begin
         q = d - 4'd3;
      end
   end

endmodule : bcd_digit_sub3

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter (reverse double dabble, one bit per cycle).
// Latency: start accepted at edge 0 -> done pulse after edge BIN_W; BIN_W+2 cycle repeat rate.
// Backpressure: none; start is ignored while busy or done, nothing is queued.
//
// Ports:
//   clk     - system clock, rising edge
//   reset   - synchronous active-high reset; aborts any conversion
//   start   - request to convert bcd_in (sampled only in IDLE)
//   bcd_in  - packed BCD, digit 0 in bits [3:0]
//   busy    - high exactly while shifting
//   done    - one-cycle pulse, bin_out/err valid
//   bin_out - registered binary result, held until the next result or reset
//   err     - invalid-digit flag, qualified by done
//
// Build option: define BCD_ERR_CHECK_EN to flag digits > 9 (err=1, bin_out=0).
// Without it err is tied low and invalid digits convert to whatever the
// shift/correct algorithm produces.
module bcd_to_bin_seq
   import bcd_pkg::*;
#(
   parameter int DIGITS = BCD_DIGITS_DEF,
   parameter int BIN_W  = BCD_BIN_W_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   bcd_in,
   output logic                  busy,
   output logic                  done,
   output logic [BIN_W-1:0]      bin_out,
   output logic                  err
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

   state_t             state_q;
   state_t             state_nx;
   logic [BCD_W-1:0]   bcd_q;
   logic [BIN_W-1:0]   bin_q;
   logic [CNT_W-1:0]   cnt_q;

   logic [BCD_W-1:0]   bcd_shift;
   logic [BCD_W-1:0]   bcd_fix;
   logic [BIN_W-1:0]   bin_shift;
   logic [BIN_W-1:0]   result;
   logic               last_iter;

   // One step: shift the whole {bcd, bin} pair right, zero into the BCD MSB;
   // the BCD LSB falls into the binary MSB.
   assign {bcd_shift, bin_shift} = {bcd_q, bin_q} >> 1;

   for (genvar g = 0; g < DIGITS; g++) begin : g_dig
      bcd_digit_sub3 u_sub3 (
         .d (bcd_shift[4*g +: 4]),
         .q (bcd_fix[4*g +: 4])
      );
   end

   assign last_iter = (cnt_q == LAST_CNT);

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_nx = state_q;
      case (state_q)
         ST_IDLE:  if (start)     state_nx = ST_SHIFT;
         ST_SHIFT: if (last_iter) state_nx = ST_DONE;
         ST_DONE:                 state_nx = ST_IDLE;
         default:                 state_nx = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // State, datapath and registered outputs
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         bin_out <= '0;
         bcd_q   <= '0;
         bin_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_nx;
         // Outputs decoded from the next state so they line up with state_q.
         busy    <= (state_nx == ST_SHIFT);
         done    <= (state_nx == ST_DONE);
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  bcd_q <= bcd_in;
                  bin_q <= '0;
                  cnt_q <= '0;
               end
            end
            ST_SHIFT: begin
               bcd_q <= bcd_fix;
               bin_q <= bin_shift;
               cnt_q <= cnt_q + CNT_W'(1);
               // The final shift's result goes straight to the output so
               // done appears on the cycle right after the last step.
               if (last_iter) begin
                  bin_out <= result;
               end
            end
            default: begin
            end
         endcase
      end
   end

`ifdef BCD_ERR_CHECK_EN
   logic inv_in;
   logic inv_q;

   always_comb begin
      inv_in = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_in[4*i +: 4] > 4'd9) begin
            inv_in = 1'b1;
         end
      end
   end

   // The invalid flag is captured with the operand and only surfaces with done.
   always_ff @(posedge clk) begin
      if (reset) begin
         inv_q <= 1'b0;
         err   <= 1'b0;
      end else begin
         if ((state_q == ST_IDLE) && start) begin
            inv_q <= inv_in;
         end
         err <= (state_q == ST_SHIFT) && last_iter && inv_q;
      end
   end

   assign result = inv_q ? '0 : bin_shift;
`else
   assign err    = 1'b0;
   assign result = bin_shift;
`endif

endmodule : bcd_to_bin_seq

// File: tb/tb_bcd_to_bin_seq.sv
// Directed bench for bcd_to_bin_seq at default parameters (4 digits, 14 bits).
// Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
module tb_bcd_to_bin_seq;

   logic        clk;
   logic        reset;
   logic        start;
   logic [15:0] bcd_in;
   logic        busy;
   logic        done;
   logic [13:0] bin_out;
   logic        err;

   int n_cmp = 0;
   int n_mis = 0;

   bcd_to_bin_seq #(
      .DIGITS (4),
      .BIN_W  (14)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .bcd_in  (bcd_in),
      .busy    (busy),
      .done    (done),
      .bin_out (bin_out),
      .err     (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Waits up to 40 edges for done; returns the edge index (1-based) or -1.
   task automatic wait_done(output int edge_n);
      edge_n = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            edge_n = i;
            return;
         end
      end
   endtask

   // One conversion: start presented for edge 0 only, bcd_in then scrambled.
   task automatic run_conv(input logic [15:0] bcd, input logic [13:0] exp_bin,
                           input logic exp_err, input bit chk_bin, input string tag);
      int e;
      @(negedge clk);
      reset  = 1'b0;
      start  = 1'b1;
      bcd_in = bcd;
      @(posedge clk);
      #1;
      chk({tag, "_busy_after_start"}, busy, 1);
      @(negedge clk);
      start  = 1'b0;
      bcd_in = 16'hFFFF;
      wait_done(e);
      chk({tag, "_done_edge"}, e, 14);
      if (chk_bin) chk({tag, "_bin"}, bin_out, exp_bin);
      chk({tag, "_err"}, err, exp_err);
      chk({tag, "_busy_at_done"}, busy, 0);
      @(posedge clk);
      #1;
      chk({tag, "_done_one_cycle"}, done, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int nd;
      int first_e;
      int e1;
      int e2;

      reset  = 1'b1;
      start  = 1'b0;
      bcd_in = 16'h0000;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_bin", bin_out, 0);

      // Start accepted on the first edge after reset release.
      run_conv(16'h9999, 14'd9999, 1'b0, 1'b1, "c9999");
      run_conv(16'h0000, 14'd0, 1'b0, 1'b1, "c0000");
      run_conv(16'h0255, 14'd255, 1'b0, 1'b1, "c0255");

      repeat (5) @(posedge clk);
      #1;
      chk("idle_hold_bin", bin_out, 255);
      chk("idle_busy", busy, 0);

      // Extra start pulses at edges 3 and 14 must be ignored.
      @(negedge clk);
      start  = 1'b1;
      bcd_in = 16'h4321;
      @(posedge clk);
      nd = 0;
      first_e = -1;
      for (int e = 1; e <= 30; e++) begin
         @(negedge clk);
         start  = (e == 3) || (e == 14);
         bcd_in = 16'h9999;
         @(posedge clk);
         #1;
         if (done) begin
            nd++;
            if (first_e < 0) first_e = e;
         end
      end
      @(negedge clk);
      start = 1'b0;
      chk("retrig_done_count", nd, 1);
      chk("retrig_done_edge", first_e, 14);
      chk("retrig_bin", bin_out, 4321);
      chk("retrig_busy_end", busy, 0);

      // Reset at edge 7 aborts the conversion.
      start  = 1'b1;
      bcd_in = 16'h1234;
      @(posedge clk);
      for (int e = 1; e <= 6; e++) begin
         @(negedge clk);
         start = 1'b0;
         @(posedge clk);
      end
      #1;
      chk("pre_abort_busy", busy, 1);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_bin", bin_out, 0);
      run_conv(16'h0042, 14'd42, 1'b0, 1'b1, "after_abort");

`ifdef BCD_ERR_CHECK_EN
      run_conv(16'h00A0, 14'd0, 1'b1, 1'b1, "invalid");
`else
      run_conv(16'h00A0, 14'd0, 1'b0, 1'b0, "invalid");
`endif

      // start held high: back-to-back conversions every 16 cycles.
      @(negedge clk);
      start  = 1'b1;
      bcd_in = 16'h1234;
      nd = 0;
      e1 = -1;
      e2 = -1;
      for (int e = 0; e < 40; e++) begin
         @(posedge clk);
         #1;
         if (done) begin
            nd++;
            if (e1 < 0) e1 = e;
            else if (e2 < 0) e2 = e;
            chk("held_bin", bin_out, 1234);
         end
      end
      @(negedge clk);
      start = 1'b0;
      chk("held_done_count", nd, 2);
      chk("held_first_edge", e1, 14);
      chk("held_second_edge", e2, 30);

      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("final_rst_busy", busy, 0);
      chk("final_rst_bin", bin_out, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule : tb_bcd_to_bin_seq
